// File: rtl/arbitro_rr_mux2x1_4b.sv
// Round-robin scheduler for two 4-bit requester FIFOs feeding one
// registered, valid-qualified output stream with ready backpressure.
module arbitro_rr_mux2x1_4b #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push0,
  input  logic [3:0] data_in0,
  input  logic       push1,
  input  logic [3:0] data_in1,
  input  logic       ready_out,
  output logic       full0,
  output logic       full1,
  output logic       empty0,
  output logic       empty1,
  output logic [1:0] overflow,
  output logic       selector,
  output logic       valid_out,
  output logic [3:0] data_out
);

  typedef enum logic [1:0] {
    IDLE,
    S0,
    S1
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [3:0]    mem0 [DEPTH];
  logic [3:0]    mem1 [DEPTH];
  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [AW:0]   cnt0, cnt1;
  logic          acc0, acc1;
  logic          gnt0, gnt1;
  logic          last_grant;
  state_t        state, state_nxt;

  assign full0  = (cnt0 == CNT_MAX);
  assign full1  = (cnt1 == CNT_MAX);
  assign empty0 = (cnt0 == '0);
  assign empty1 = (cnt1 == '0);
  assign acc0   = push0 && !full0;
  assign acc1   = push1 && !full1;

  assign valid_out = (state != IDLE);

  // Both busy: strict alternation against the last winner.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    if (ready_out) begin
      if (!empty0 && !empty1) begin
        if (last_grant) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (!empty0) begin
        gnt0 = 1'b1;
      end else if (!empty1) begin
        gnt1 = 1'b1;
      end
    end
    unique case (1'b1)
      gnt0:    state_nxt = S0;
      gnt1:    state_nxt = S1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc0) mem0[wp0] <= data_in0;
    if (acc1) mem1[wp1] <= data_in1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp0      <= '0;
      rp0      <= '0;
      cnt0     <= '0;
      wp1      <= '0;
      rp1      <= '0;
      cnt1     <= '0;
      overflow <= '0;
    end else begin
      if (acc0) wp0 <= wp0 + PTR_ONE;
      if (gnt0) rp0 <= rp0 + PTR_ONE;
      if (acc1) wp1 <= wp1 + PTR_ONE;
      if (gnt1) rp1 <= rp1 + PTR_ONE;
      unique case ({acc0, gnt0})
        2'b10:   cnt0 <= cnt0 + CNT_ONE;
        2'b01:   cnt0 <= cnt0 - CNT_ONE;
        default: cnt0 <= cnt0;
      endcase
      unique case ({acc1, gnt1})
        2'b10:   cnt1 <= cnt1 + CNT_ONE;
        2'b01:   cnt1 <= cnt1 - CNT_ONE;
        default: cnt1 <= cnt1;
      endcase
      if (push0 && full0) overflow[0] <= 1'b1;
      if (push1 && full1) overflow[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      selector   <= 1'b0;
      data_out   <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt0) begin
        data_out   <= mem0[rp0];
        selector   <= 1'b0;
        last_grant <= 1'b0;
      end else if (gnt1) begin
        data_out   <= mem1[rp1];
        selector   <= 1'b1;
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_rr_mux2x1_4b.sv
// Scoreboard bench: directed pushes queue expected {selector,data};
// a negedge monitor pops and compares every valid_out word.
module tb_arbitro_rr_mux2x1_4b;

  logic       clk;
  logic       reset;
  logic       push0;
  logic [3:0] data_in0;
  logic       push1;
  logic [3:0] data_in1;
  logic       ready_out;
  logic       full0, full1;
  logic       empty0, empty1;
  logic [1:0] overflow;
  logic       selector;
  logic       valid_out;
  logic [3:0] data_out;

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [4:0] exp_q [$];

  arbitro_rr_mux2x1_4b #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .push0     (push0),
    .data_in0  (data_in0),
    .push1     (push1),
    .data_in1  (data_in1),
    .ready_out (ready_out),
    .full0     (full0),
    .full1     (full1),
    .empty0    (empty0),
    .empty1    (empty1),
    .overflow  (overflow),
    .selector  (selector),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic sel, input logic [3:0] d);
    exp_q.push_back({sel, d});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (mon_en && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got sel=%0d data=%h, none expected",
                 selector, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({selector, data_out} !== e) begin
          errors++;
          $display("FAIL out_word: got sel=%0d data=%h expected sel=%0d data=%h",
                   selector, data_out, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    push0     = 1'b1;
    data_in0  = 4'h5;
    push1     = 1'b0;
    data_in1  = 4'h0;
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push0 = 1'b0;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sel", selector, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_empty0", empty0, 1);
    chk("rst_empty1", empty1, 1);
    chk("rst_full0", full0, 0);
    mon_en = 1'b1;
    tick();
    chk("rst_fifo0_still_empty", empty0, 1);

    // single channel on ch1
    expect_word(1'b1, 4'hA);
    expect_word(1'b1, 4'hB);
    expect_word(1'b1, 4'hC);
    push1 = 1'b1;
    data_in1 = 4'hA;
    tick();
    chk("lat_first_cycle", valid_out, 0);
    data_in1 = 4'hB;
    tick();
    chk("lat_second_cycle", valid_out, 1);
    data_in1 = 4'hC;
    tick();
    push1 = 1'b0;
    wait_drain("single_drain");

    // contention
    ready_out = 1'b0;
    push0 = 1'b1;
    push1 = 1'b1;
    data_in0 = 4'h1;
    data_in1 = 4'h9;
    tick();
    data_in0 = 4'h2;
    data_in1 = 4'h8;
    tick();
    push0 = 1'b0;
    push1 = 1'b0;
    expect_word(1'b0, 4'h1);
    expect_word(1'b1, 4'h9);
    expect_word(1'b0, 4'h2);
    expect_word(1'b1, 4'h8);
    ready_out = 1'b1;
    wait_drain("contention_drain");

    // backpressure
    ready_out = 1'b0;
    push0 = 1'b1;
    data_in0 = 4'h3;
    tick();
    push0 = 1'b0;
    expect_word(1'b0, 4'h3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid_low", valid_out, 0);
      chk("bp_fifo0_held", empty0, 0);
    end
    ready_out = 1'b1;
    wait_drain("bp_drain");
    chk("bp_empty0", empty0, 1);
    chk("bp_valid_after", valid_out, 0);

    // overflow
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push0 = 1'b1;
      data_in0 = 4'(4 + i);
      tick();
      if (i == 3) begin
        chk("ovf_full_at4", full0, 1);
        chk("ovf_clear_at4", overflow, 0);
      end
    end
    push0 = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_still_full", full0, 1);
    for (int i = 0; i < 4; i++) expect_word(1'b0, 4'(4 + i));
    ready_out = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_empty0", empty0, 1);
    chk("ovf_full0_clear", full0, 0);

    // wrap + mid-op reset
    for (int w = 1; w <= 5; w++) expect_word(1'b1, 4'(w));
    push1 = 1'b1;
    for (int w = 1; w <= 6; w++) begin
      data_in1 = 4'(w);
      tick();
    end
    reset = 1'b1;
    data_in1 = 4'h7;
    tick();
    reset = 1'b0;
    push1 = 1'b0;
    chk("mid_rst_words_1_5", exp_q.size(), 0);
    chk("mid_rst_empty1", empty1, 1);
    chk("mid_rst_ovf_clear", overflow, 0);
    chk("mid_rst_valid", valid_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", valid_out, 0);
    end
    expect_word(1'b0, 4'hD);
    expect_word(1'b1, 4'h8);
    expect_word(1'b1, 4'h9);
    expect_word(1'b1, 4'hA);
    push0 = 1'b1;
    data_in0 = 4'hD;
    push1 = 1'b1;
    data_in1 = 4'h8;
    tick();
    push0 = 1'b0;
    data_in1 = 4'h9;
    tick();
    data_in1 = 4'hA;
    tick();
    push1 = 1'b0;
    wait_drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
